// File: rtl/prog_pkg.sv
// Shared encoding definitions for the program encoder and the control decoder:
// opcode enum, field widths and the opcode legality helper.
package prog_pkg;

  localparam int OPW  = 4;
  localparam int ARGW = 5;
  localparam int IW   = OPW + ARGW;

  typedef enum logic [OPW-1:0] {
    OP_LOAD   = 4'h0,
    OP_STORE  = 4'h1,
    OP_XOR    = 4'h2,
    OP_BNE    = 4'h3,
    OP_ADD    = 4'h4,
    OP_MV     = 4'h5,
    OP_LSHIFT = 4'h6,
    OP_RSHIFT = 4'h7,
    OP_LOADI  = 4'h8,
    OP_PARI   = 4'h9,
    OP_HALT   = 4'hA,
    OP_OR     = 4'hB,
    OP_SUB    = 4'hC
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_t;

  // Codes above OP_SUB have no instruction behind them.
  function automatic logic op_legal(op_t op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/prog_encoder.sv
// Packs (opcode, operand) tokens into 9-bit words and streams them to the
// instruction-memory write port. Optional operand checking: PROG_ENCODER_ARGCHK_EN.
module prog_encoder
  import prog_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_arg,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          done,
  output logic          err,
  output logic [AW:0]   prog_len
);

  state_t        state;
  logic [AW-1:0] cnt;
  op_t           op;
  logic          accept;
  logic          is_halt;
  logic          at_last;
  logic          legal;

  assign op       = op_t'(in_op);
  assign in_ready = (state == ST_LOAD) && !start;
  assign accept   = in_valid && in_ready;
  assign is_halt  = (op == OP_HALT);
  assign at_last  = (cnt == AW'(DEPTH - 1));

  // NOTE: every variable driven here gets a value first, so no latch is inferred.
  always_comb begin
    legal = op_legal(op);
`ifdef PROG_ENCODER_ARGCHK_EN
    if (is_halt && (in_arg != '0))
      legal = 1'b0;
    if (((op == OP_LSHIFT) || (op == OP_RSHIFT)) && (in_arg > 5'd8))
      legal = 1'b0;
`else
    legal = legal;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, so it is tested inside the clocked block rather than listed.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      prog_len   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        state    <= ST_LOAD;
        cnt      <= '0;
        prog_len <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
      end else if (accept) begin
        // The last address is kept for HALT so every program can terminate.
        if (!legal || (at_last && !is_halt)) begin
          state <= ST_ERR;
          err   <= 1'b1;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= cnt;
          imem_wdata <= {in_op, in_arg};
          prog_len   <= prog_len + (AW+1)'(1);
          if (!at_last)
            cnt <= cnt + AW'(1);
          if (is_halt) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_encoder.sv
// Directed, table-driven bench for prog_encoder; a second DEPTH=4 instance
// exercises the overflow boundary.
module tb_prog_encoder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic       in_valid;
  logic [3:0] in_op;
  logic [4:0] in_arg;

  logic        in_ready,  imem_we,  done,  err;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_wdata;
  logic [10:0] prog_len;

  logic        in_ready4, imem_we4, done4, err4;
  logic [1:0]  imem_addr4;
  logic [8:0]  imem_wdata4;
  logic [2:0]  prog_len4;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  prog_encoder #(.DEPTH(1024)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_arg(in_arg),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .err(err), .prog_len(prog_len)
  );

  prog_encoder #(.DEPTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready4), .in_op(in_op), .in_arg(in_arg),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .done(done4), .err(err4), .prog_len(prog_len4)
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [3:0]  op;
    logic [4:0]  arg;
    logic        ready;
    logic        we;
    logic [9:0]  addr;
    logic [8:0]  wdata;
    logic        done;
    logic        err;
    logic [10:0] len;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [3:0] op, input logic [4:0] arg);
    start    = s;
    in_valid = v;
    in_op    = op;
    in_arg   = arg;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic s, input logic v, input logic [3:0] op, input logic [4:0] arg,
                     input logic rdy, input logic we, input logic [9:0] addr,
                     input logic [8:0] wd, input logic dn, input logic er, input logic [10:0] len);
    vec_t r;
    r.start = s;  r.valid = v;  r.op = op;    r.arg = arg;
    r.ready = rdy; r.we = we;   r.addr = addr; r.wdata = wd;
    r.done = dn;  r.err = er;   r.len = len;
    vecs.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 5'd0);
    step();
    step();
    check("rst_ready", in_ready,   0);
    check("rst_we",    imem_we,    0);
    check("rst_addr",  imem_addr,  0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_done",  done,       0);
    check("rst_err",   err,        0);
    check("rst_len",   prog_len,   0);
    Reset = 1'b0;

    //   start valid op     arg    rdy   we   addr   wdata   done err  len
    add(1, 0, 4'h0, 5'd0,  0, 0, 0, 9'h000, 0, 0, 0);
    add(0, 1, 4'h8, 5'd3,  1, 1, 0, 9'h103, 0, 0, 1);
    add(0, 1, 4'h4, 5'd1,  1, 1, 1, 9'h081, 0, 0, 2);
    add(0, 1, 4'hA, 5'd0,  1, 1, 2, 9'h140, 1, 0, 3);
    add(0, 0, 4'h0, 5'd0,  0, 0, 0, 9'h000, 1, 0, 3);
    add(0, 1, 4'h4, 5'd1,  0, 0, 0, 9'h000, 1, 0, 3);
    add(1, 0, 4'h0, 5'd0,  0, 0, 0, 9'h000, 0, 0, 0);
    add(0, 1, 4'hE, 5'd0,  1, 0, 0, 9'h000, 0, 1, 0);
    add(0, 1, 4'h4, 5'd1,  0, 0, 0, 9'h000, 0, 1, 0);
    add(1, 0, 4'h0, 5'd0,  0, 0, 0, 9'h000, 0, 0, 0);
    add(1, 1, 4'h0, 5'd5,  0, 0, 0, 9'h000, 0, 0, 0);
    add(0, 1, 4'h0, 5'd5,  1, 1, 0, 9'h005, 0, 0, 1);
    add(0, 1, 4'h1, 5'd31, 1, 1, 1, 9'h03F, 0, 0, 2);
    add(1, 0, 4'h0, 5'd0,  0, 0, 0, 9'h000, 0, 0, 0);
`ifdef PROG_ENCODER_ARGCHK_EN
    add(0, 1, 4'h6, 5'd9,  1, 0, 0, 9'h000, 0, 1, 0);
    add(1, 0, 4'h0, 5'd0,  0, 0, 0, 9'h000, 0, 0, 0);
    add(0, 1, 4'hA, 5'd1,  1, 0, 0, 9'h000, 0, 1, 0);
`else
    add(0, 1, 4'h6, 5'd9,  1, 1, 0, 9'h0C9, 0, 0, 1);
    add(1, 0, 4'h0, 5'd0,  0, 0, 0, 9'h000, 0, 0, 0);
    add(0, 1, 4'hA, 5'd1,  1, 1, 0, 9'h141, 1, 0, 1);
`endif
    add(1, 0, 4'h0, 5'd0,  0, 0, 0, 9'h000, 0, 0, 0);
    add(0, 1, 4'h7, 5'd8,  1, 1, 0, 9'h0E8, 0, 0, 1);
    add(0, 1, 4'hD, 5'd0,  1, 0, 0, 9'h000, 0, 1, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].valid, vecs[i].op, vecs[i].arg);
      #1;
      check($sformatf("v%0d_ready", i), in_ready, vecs[i].ready);
      step();
      check($sformatf("v%0d_we", i),   imem_we,  vecs[i].we);
      check($sformatf("v%0d_done", i), done,     vecs[i].done);
      check($sformatf("v%0d_err", i),  err,      vecs[i].err);
      check($sformatf("v%0d_len", i),  prog_len, vecs[i].len);
      if (vecs[i].we) begin
        check($sformatf("v%0d_addr", i),  imem_addr,  vecs[i].addr);
        check($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].wdata);
      end
    end

    // DEPTH=4: the fourth non-HALT token hits the reserved last slot.
    drive(1, 0, 4'h0, 5'd0); step();
    drive(0, 1, 4'h0, 5'd1); step();
    check("d4_w0_addr", imem_addr4, 0);
    drive(0, 1, 4'h1, 5'd2); step();
    check("d4_w1_addr", imem_addr4, 1);
    drive(0, 1, 4'h4, 5'd3); step();
    check("d4_w2_addr",  imem_addr4,  2);
    check("d4_w2_wdata", imem_wdata4, 9'h083);
    check("d4_w2_len",   prog_len4,   3);
    drive(0, 1, 4'h2, 5'd2); #1;
    check("d4_ovf_ready", in_ready4, 1);
    step();
    check("d4_ovf_we",  imem_we4,  0);
    check("d4_ovf_err", err4,      1);
    check("d4_ovf_len", prog_len4, 3);
    drive(0, 0, 4'h0, 5'd0); #1;
    check("d4_err_ready", in_ready4, 0);

    drive(1, 0, 4'h0, 5'd0); step();
    check("d4_restart_err", err4, 0);
    check("d4_restart_len", prog_len4, 0);
    drive(0, 1, 4'h0, 5'd1); step();
    drive(0, 1, 4'h1, 5'd2); step();
    drive(0, 1, 4'h4, 5'd3); step();
    drive(0, 1, 4'hA, 5'd0); step();
    check("d4_halt_we",    imem_we4,    1);
    check("d4_halt_addr",  imem_addr4,  3);
    check("d4_halt_wdata", imem_wdata4, 9'h140);
    check("d4_halt_done",  done4,       1);
    check("d4_halt_err",   err4,        0);
    check("d4_halt_len",   prog_len4,   4);
    drive(0, 0, 4'h0, 5'd0); step();
    check("d4_after_we", imem_we4, 0);

    // Reset the cycle after acceptance: the write strobe must not survive it.
    drive(1, 0, 4'h0, 5'd0); step();
    drive(0, 1, 4'h0, 5'd7); step();
    check("mr_pending_we", imem_we, 1);
    drive(0, 0, 4'h0, 5'd0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mr_we",    imem_we,    0);
    check("mr_ready", in_ready,   0);
    check("mr_addr",  imem_addr,  0);
    check("mr_wdata", imem_wdata, 0);
    check("mr_done",  done,       0);
    check("mr_err",   err,        0);
    check("mr_len",   prog_len,   0);
    step();
    check("mr_we2", imem_we, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
